// File: rtl/capture_ctrl.sv
// capture_ctrl: acquisition sequencer that owns the sample RAM write port.
// It runs the RAM as a circular buffer: pre-fill, wait for a level/slope
// trigger, capture a fixed post-trigger count, then freeze the buffer and
// hand it to the readout path until pi_graph_done.
// Optional feature macro: CAPTURE_CTRL_AUTO_TRIG_EN (forced trigger after
// AUTO_TIMEOUT valid samples in ARMED; trig_forced is tied 0 without it).
module capture_ctrl #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int PRETRIG = 1024
`ifdef CAPTURE_CTRL_AUTO_TRIG_EN
  , parameter int AUTO_TIMEOUT = 65535
`endif
) (
  input  logic              osc_clk,
  input  logic              reset,
  input  logic              run,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic              pi_graph_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_adr,
  output logic [DATA_W-1:0] wr_data,
  output logic              start_read,
  output logic [ADDR_W-1:0] rd_base,
  output logic [ADDR_W-1:0] trig_adr,
  output logic              trig_forced,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int POSTN = DEPTH - PRETRIG - 1;
  localparam logic [ADDR_W-1:0] ZERO_A    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PRE_A     = ADDR_W'(PRETRIG);
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRETRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POSTN - 1);
  localparam bit PRE_ZERO  = (PRETRIG == 0);
  localparam bit POST_ZERO = (POSTN == 0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PREFILL = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_HANDOFF = 3'd4
  } state_t;

  // The state a new acquisition starts in (PREFILL is skipped with no pre-trigger history)
  localparam state_t S_START = PRE_ZERO ? S_ARMED : S_PREFILL;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              have_prev_q, have_prev_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_adr_q, wr_adr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              start_read_q, start_read_d;
  logic [ADDR_W-1:0] rd_base_q, rd_base_d;
  logic [ADDR_W-1:0] trig_adr_q, trig_adr_d;
  logic              busy_q, busy_d;
  logic              forced_q, forced_d;
`ifdef CAPTURE_CTRL_AUTO_TRIG_EN
  logic [31:0]       to_cnt_q, to_cnt_d;
  logic              timeout_hit;
`endif
  logic              crossing;
  logic              fire;

  // Trigger qualification on the incoming sample against the previous one
  always_comb begin
    crossing = 1'b0;
    if (have_prev_q) begin
      if (trig_slope) begin
        crossing = (prev_q >= trig_level) && (sample_data < trig_level);
      end else begin
        crossing = (prev_q < trig_level) && (sample_data >= trig_level);
      end
    end else begin
      crossing = 1'b0;
    end
`ifdef CAPTURE_CTRL_AUTO_TRIG_EN
    timeout_hit = ((to_cnt_q + 32'd1) == 32'(AUTO_TIMEOUT));
    fire        = crossing || timeout_hit;
`else
    fire        = crossing;
`endif
  end

  // Next-state, write path and frame bookkeeping
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    have_prev_d  = have_prev_q;
    prev_d       = prev_q;
    wr_en_d      = 1'b0;
    wr_adr_d     = wr_adr_q;
    wr_data_d    = wr_data_q;
    start_read_d = start_read_q;
    rd_base_d    = rd_base_q;
    trig_adr_d   = trig_adr_q;
    forced_d     = forced_q;
`ifdef CAPTURE_CTRL_AUTO_TRIG_EN
    to_cnt_d     = to_cnt_q;
`endif

    // A sample arriving on a state-exit edge is still handled by the current state
    if (sample_valid && (state_q == S_PREFILL || state_q == S_ARMED || state_q == S_POST)) begin
      wr_en_d   = 1'b1;
      wr_adr_d  = ptr_q;
      wr_data_d = sample_data;
      ptr_d     = ptr_q + ONE_A;
    end else begin
      wr_en_d   = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (run && !pi_graph_done) begin
          state_d     = S_START;
          ptr_d       = ZERO_A;
          have_prev_d = 1'b0;
`ifdef CAPTURE_CTRL_AUTO_TRIG_EN
          to_cnt_d    = 32'd0;
`endif
        end else begin
          state_d     = S_IDLE;
        end
      end

      S_PREFILL: begin
        if (pi_graph_done || !run) begin
          state_d = S_IDLE;
          ptr_d   = ZERO_A;
        end else if (sample_valid) begin
          have_prev_d = 1'b1;
          prev_d      = sample_data;
          if (ptr_q == PRE_LAST) begin
            state_d  = S_ARMED;
`ifdef CAPTURE_CTRL_AUTO_TRIG_EN
            to_cnt_d = 32'd0;
`endif
          end else begin
            state_d  = S_PREFILL;
          end
        end else begin
          state_d = S_PREFILL;
        end
      end

      S_ARMED: begin
        if (pi_graph_done || !run) begin
          state_d = S_IDLE;
          ptr_d   = ZERO_A;
        end else if (sample_valid) begin
          have_prev_d = 1'b1;
          prev_d      = sample_data;
`ifdef CAPTURE_CTRL_AUTO_TRIG_EN
          to_cnt_d    = to_cnt_q + 32'd1;
`endif
          if (fire) begin
            trig_adr_d = ptr_q;
            rd_base_d  = ptr_q - PRE_A;
            forced_d   = !crossing;
            cnt_d      = ZERO_A;
            state_d    = POST_ZERO ? S_HANDOFF : S_POST;
          end else begin
            state_d    = S_ARMED;
          end
        end else begin
          state_d = S_ARMED;
        end
      end

      S_POST: begin
        if (pi_graph_done) begin
          state_d = S_IDLE;
          ptr_d   = ZERO_A;
        end else if (sample_valid) begin
          if (cnt_q == POST_LAST) begin
            state_d = S_HANDOFF;
          end else begin
            cnt_d   = cnt_q + ONE_A;
          end
        end else begin
          state_d = S_POST;
        end
      end

      S_HANDOFF: begin
        if (pi_graph_done) begin
          start_read_d = 1'b0;
          ptr_d        = ZERO_A;
          have_prev_d  = 1'b0;
          state_d      = run ? S_START : S_IDLE;
`ifdef CAPTURE_CTRL_AUTO_TRIG_EN
          to_cnt_d     = 32'd0;
`endif
        end else begin
          start_read_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        ptr_d   = ZERO_A;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge osc_clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= ZERO_A;
      cnt_q        <= ZERO_A;
      have_prev_q  <= 1'b0;
      prev_q       <= {DATA_W{1'b0}};
      wr_en_q      <= 1'b0;
      wr_adr_q     <= ZERO_A;
      wr_data_q    <= {DATA_W{1'b0}};
      start_read_q <= 1'b0;
      rd_base_q    <= ZERO_A;
      trig_adr_q   <= ZERO_A;
      busy_q       <= 1'b0;
      forced_q     <= 1'b0;
`ifdef CAPTURE_CTRL_AUTO_TRIG_EN
      to_cnt_q     <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      have_prev_q  <= have_prev_d;
      prev_q       <= prev_d;
      wr_en_q      <= wr_en_d;
      wr_adr_q     <= wr_adr_d;
      wr_data_q    <= wr_data_d;
      start_read_q <= start_read_d;
      rd_base_q    <= rd_base_d;
      trig_adr_q   <= trig_adr_d;
      busy_q       <= busy_d;
      forced_q     <= forced_d;
`ifdef CAPTURE_CTRL_AUTO_TRIG_EN
      to_cnt_q     <= to_cnt_d;
`endif
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_adr     = wr_adr_q;
  assign wr_data    = wr_data_q;
  assign start_read = start_read_q;
  assign rd_base    = rd_base_q;
  assign trig_adr   = trig_adr_q;
  assign busy       = busy_q;
`ifdef CAPTURE_CTRL_AUTO_TRIG_EN
  assign trig_forced = forced_q;
`else
  assign trig_forced = 1'b0;
`endif

endmodule
